crossbar_rr_arb: RTL and testbench

//  N-master ownership arbiter for the crossbar; successor to the fixed 16-way owner control.

---
 rtl/crossbar_rr_arb.sv | 147 ++++++++++++++
 tb/tb_crossbar_rr_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_rr_arb.sv
// Round-robin ownership arbiter for the crossbar: one registered owner at a time,
// optional hold limit, one idle turnaround cycle between successive owners.
module crossbar_rr_arb #(
  parameter int NUM_MASTERS = 16,
  parameter int MAX_HOLD    = 0,
  parameter int IDX_W       = $clog2(NUM_MASTERS),
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   owner_valid,
  output logic [IDX_W-1:0]       owner_idx,
  output logic                   set_owner,
  output logic                   clr_owner,
  output logic                   hold_expired,
  output logic                   o_dbg_busy,
  output logic [IDX_W-1:0]       o_dbg_rr_ptr
);

  // Protocol: request is a level held by a master for as long as it wants the bus;
  // grant (registered) answers one cycle later and is withdrawn one cycle after the
  // owner's request drops or a forced release is taken. There is no back-pressure.

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic                   r_owner_valid, w_owner_valid_nxt;
  logic [IDX_W-1:0]       r_owner_idx, w_owner_idx_nxt;
  logic                   r_set, w_set_nxt;
  logic                   r_clr, w_clr_nxt;
  logic                   r_exp, w_exp_nxt;
  logic [IDX_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]       r_hold_cnt, w_hold_cnt_nxt;

  logic                   w_up_found;
  logic [IDX_W-1:0]       w_up_idx;
  logic [IDX_W-1:0]       w_any_idx;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_owner_req;
  logic                   w_others;
  logic                   w_force;

  // Scanning downwards leaves the lowest qualifying index in each candidate.
  always_comb begin
    w_up_found = 1'b0;
    w_up_idx   = '0;
    w_any_idx  = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (request[i]) begin
        w_any_idx = IDX_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_up_found = 1'b1;
          w_up_idx   = IDX_W'(i);
        end
      end
    end
    w_win_idx = w_up_found ? w_up_idx : w_any_idx;
  end

  // The limit test is ">=" so a lone owner that ran past the limit still yields
  // as soon as a competitor shows up (the counter saturates rather than wraps).
  always_comb begin
    w_owner_req = request[r_owner_idx];
    w_others    = |(request & ~r_grant);
    w_force     = (MAX_HOLD != 0) && (r_hold_cnt >= HOLD_LIM) && w_others;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_owner_valid_nxt = r_owner_valid;
    w_owner_idx_nxt   = r_owner_idx;
    w_set_nxt         = 1'b0;
    w_clr_nxt         = 1'b0;
    w_exp_nxt         = 1'b0;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_hold_cnt_nxt    = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (|request) begin
          w_state_nxt              = ST_BUSY;
          w_grant_nxt              = '0;
          w_grant_nxt[w_win_idx]   = 1'b1;
          w_owner_valid_nxt        = 1'b1;
          w_owner_idx_nxt          = w_win_idx;
          w_set_nxt                = 1'b1;
          w_hold_cnt_nxt           = '0;
        end
      end
      ST_BUSY: begin
        if (r_hold_cnt != {CNT_W{1'b1}}) begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
        if (!w_owner_req || w_force) begin
          w_state_nxt       = ST_IDLE;
          w_grant_nxt       = '0;
          w_owner_valid_nxt = 1'b0;
          w_clr_nxt         = 1'b1;
          w_exp_nxt         = w_owner_req;
          w_hold_cnt_nxt    = '0;
          w_rr_ptr_nxt      = (r_owner_idx == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                       : r_owner_idx + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_owner_valid <= 1'b0;
      r_owner_idx   <= '0;
      r_set         <= 1'b0;
      r_clr         <= 1'b0;
      r_exp         <= 1'b0;
      r_rr_ptr      <= '0;
      r_hold_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_owner_valid <= w_owner_valid_nxt;
      r_owner_idx   <= w_owner_idx_nxt;
      r_set         <= w_set_nxt;
      r_clr         <= w_clr_nxt;
      r_exp         <= w_exp_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
    end
  end

  assign grant        = r_grant;
  assign owner_valid  = r_owner_valid;
  assign owner_idx    = r_owner_idx;
  assign set_owner    = r_set;
  assign clr_owner    = r_clr;
  assign hold_expired = r_exp;
  assign o_dbg_busy   = (r_state == ST_BUSY);
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_crossbar_rr_arb.sv
// Bench for crossbar_rr_arb: two instances (unlimited hold, hold limit 4) share one
// request bus; directed vector table plus a random soak against a tenure-level model.
module tb_crossbar_rr_arb;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  request;

  logic [N-1:0]  grant_w [2];
  logic          valid_w [2];
  logic [IW-1:0] idx_w   [2];
  logic          set_w   [2];
  logic          clr_w   [2];
  logic          exp_w   [2];
  logic          busy_w  [2];
  logic [IW-1:0] rr_w    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  crossbar_rr_arb #(.NUM_MASTERS(N), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .request(request),
    .grant(grant_w[0]), .owner_valid(valid_w[0]), .owner_idx(idx_w[0]),
    .set_owner(set_w[0]), .clr_owner(clr_w[0]), .hold_expired(exp_w[0]),
    .o_dbg_busy(busy_w[0]), .o_dbg_rr_ptr(rr_w[0])
  );

  crossbar_rr_arb #(.NUM_MASTERS(N), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .request(request),
    .grant(grant_w[1]), .owner_valid(valid_w[1]), .owner_idx(idx_w[1]),
    .set_owner(set_w[1]), .clr_owner(clr_w[1]), .hold_expired(exp_w[1]),
    .o_dbg_busy(busy_w[1]), .o_dbg_rr_ptr(rr_w[1])
  );

  // Reference model: who owns the bus, for how many cycles, and where the search starts.
  int m_owner [2];
  int m_last  [2];
  int m_ptr   [2];
  int m_ten   [2];
  bit m_set   [2];
  bit m_clr   [2];
  bit m_exp   [2];
  int wait_cnt [2][N];

  function automatic int max_hold(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d]  = 0;
      m_ptr[d]   = 0;
      m_ten[d]   = 0;
      m_set[d]   = 0;
      m_clr[d]   = 0;
      m_exp[d]   = 0;
      for (int i = 0; i < N; i++) wait_cnt[d][i] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] req);
    for (int d = 0; d < 2; d++) begin
      m_set[d] = 0;
      m_clr[d] = 0;
      m_exp[d] = 0;
      if (m_owner[d] < 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr[d] + k) % N;
          if (req[j] && m_owner[d] < 0) begin
            m_owner[d] = j;
            m_last[d]  = j;
            m_ten[d]   = 1;
            m_set[d]   = 1;
          end
        end
      end else begin
        bit own_req, others, forced;
        own_req = req[m_owner[d]];
        others  = 0;
        for (int i = 0; i < N; i++) if (i != m_owner[d] && req[i]) others = 1;
        forced  = (max_hold(d) != 0) && (m_ten[d] >= max_hold(d)) && others;
        if (!own_req || forced) begin
          m_clr[d]   = 1;
          m_exp[d]   = own_req;
          m_ptr[d]   = (m_owner[d] + 1) % N;
          m_owner[d] = -1;
        end else begin
          m_ten[d]++;
        end
      end
    end
  endtask

  task automatic compare_model(input logic [N-1:0] req, input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] eg;
      int worst;
      string p;
      p  = $sformatf("%s d%0d", tag, d);
      eg = '0;
      if (m_owner[d] >= 0) eg[m_owner[d]] = 1'b1;
      check({p, " grant"},    32'(grant_w[d]), 32'(eg));
      check({p, " valid"},    32'(valid_w[d]), 32'(m_owner[d] >= 0));
      check({p, " idx"},      32'(idx_w[d]),   32'(m_last[d]));
      check({p, " set"},      32'(set_w[d]),   32'(m_set[d]));
      check({p, " clr"},      32'(clr_w[d]),   32'(m_clr[d]));
      check({p, " expired"},  32'(exp_w[d]),   32'(m_exp[d]));
      check({p, " busy"},     32'(busy_w[d]),  32'(m_owner[d] >= 0));
      check({p, " rr_ptr"},   32'(rr_w[d]),    32'(m_ptr[d]));
      check({p, " onehot0"},  32'($onehot0(grant_w[d])), 32'd1);
      check({p, " set&clr"},  32'(set_w[d] & clr_w[d]), 32'd0);
      worst = 0;
      for (int i = 0; i < N; i++) begin
        if (!req[i]) wait_cnt[d][i] = 0;
        else if (set_w[d] && grant_w[d][i]) wait_cnt[d][i] = 0;
        else if (set_w[d]) wait_cnt[d][i]++;
        if (wait_cnt[d][i] > worst) worst = wait_cnt[d][i];
      end
      if (set_w[d]) check({p, " starvation"}, 32'(worst > N), 32'd0);
    end
  endtask

  task automatic step(input logic [N-1:0] req, input string tag);
    request = req;
    @(posedge clk);
    model_step(req);
    @(negedge clk);
    compare_model(req, tag);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    request = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_model('0, "reset");
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit           rst;
    int           d;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    bit           s;
    bit           c;
    bit           e;
    int           rr;
  } vec_t;

  vec_t vt[$];

  initial begin
    rst_n   = 1'b0;
    request = '0;

    // T1
    vt.push_back('{1, 0, 16'h0004, 16'h0004, 1, 0, 0, -1});
    vt.push_back('{0, 0, 16'h0004, 16'h0004, 0, 0, 0, -1});
    vt.push_back('{0, 0, 16'h0004, 16'h0004, 0, 0, 0, -1});
    vt.push_back('{0, 0, 16'h0000, 16'h0000, 0, 1, 0,  3});
    // T2 then T3 (wrap from owner 15)
    vt.push_back('{1, 0, 16'h8001, 16'h0001, 1, 0, 0, -1});
    vt.push_back('{0, 0, 16'h8000, 16'h0000, 0, 1, 0,  1});
    vt.push_back('{0, 0, 16'h8000, 16'h8000, 1, 0, 0, -1});
    vt.push_back('{0, 0, 16'h0001, 16'h0000, 0, 1, 0,  0});
    vt.push_back('{0, 0, 16'h8001, 16'h0001, 1, 0, 0, -1});
    vt.push_back('{0, 0, 16'h0000, 16'h0000, 0, 1, 0,  1});
    // T4: hold limit 4 with a competitor
    vt.push_back('{1, 1, 16'h0024, 16'h0004, 1, 0, 0, -1});
    for (int i = 0; i < 3; i++) vt.push_back('{0, 1, 16'h0024, 16'h0004, 0, 0, 0, -1});
    vt.push_back('{0, 1, 16'h0024, 16'h0000, 0, 1, 1,  3});
    vt.push_back('{0, 1, 16'h0024, 16'h0020, 1, 0, 0, -1});
    vt.push_back('{0, 1, 16'h0000, 16'h0000, 0, 1, 0,  6});
    // T5: lone requester past the limit, then a competitor arrives
    vt.push_back('{1, 1, 16'h0004, 16'h0004, 1, 0, 0, -1});
    for (int i = 0; i < 9; i++) vt.push_back('{0, 1, 16'h0004, 16'h0004, 0, 0, 0, -1});
    vt.push_back('{0, 1, 16'h0024, 16'h0000, 0, 1, 1,  3});
    vt.push_back('{0, 1, 16'h0024, 16'h0020, 1, 0, 0, -1});
    vt.push_back('{0, 1, 16'h0000, 16'h0000, 0, 1, 0,  6});

    do_reset();
    foreach (vt[k]) begin
      string tag;
      int d;
      tag = $sformatf("vec%0d", k);
      d   = vt[k].d;
      if (vt[k].rst) do_reset();
      step(vt[k].req, tag);
      check({tag, " tbl grant"},   32'(grant_w[d]), 32'(vt[k].grant));
      check({tag, " tbl set"},     32'(set_w[d]),   32'(vt[k].s));
      check({tag, " tbl clr"},     32'(clr_w[d]),   32'(vt[k].c));
      check({tag, " tbl expired"}, 32'(exp_w[d]),   32'(vt[k].e));
      if (vt[k].rr >= 0) check({tag, " tbl rr_ptr"}, 32'(rr_w[d]), 32'(vt[k].rr));
    end

    // T6: asynchronous reset in the middle of a tenure
    do_reset();
    step(16'h0010, "t6a");
    step(16'h0010, "t6b");
    check("t6 pre grant", 32'(grant_w[0]), 32'h0010);
    rst_n = 1'b0;
    #1;
    check("t6 async grant", 32'(grant_w[0]), 32'h0);
    check("t6 async valid", 32'(valid_w[0]), 32'h0);
    check("t6 async clr",   32'(clr_w[0]),   32'h0);
    check("t6 async set",   32'(set_w[0]),   32'h0);
    do_reset();
    check("t6 rr after reset", 32'(rr_w[0]), 32'h0);
    step(16'h0010, "t6c");
    check("t6 regrant", 32'(grant_w[0]), 32'h0010);
    check("t6 reset",   32'(set_w[0]),   32'h1);

    // Random soak: sticky requests with sparse bit flips
    do_reset();
    begin
      logic [N-1:0] r;
      r = '0;
      for (int c = 0; c < 4000; c++) begin
        r = r ^ N'($urandom & $urandom & $urandom);
        if ($urandom_range(0, 199) == 0) r = '0;
        step(r, "soak");
      end
    end
    request = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
